// File: rtl/profiler_snapshot_streamer_pkg.sv
// Shared types and helpers for the cache-profiler readout units.
// Contents:
//   stream_state_t     - states of the snapshot streaming FSM
//   HEADER_TAG_DEFAULT - default tag placed in header bits [31:16]
//   build_header()     - assembles {tag, sequence number, word count}
package profiler_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_HDR  = 2'd1,
    SEND_CNT  = 2'd2,
    SEND_CSUM = 2'd3
  } stream_state_t;

  localparam logic [15:0] HEADER_TAG_DEFAULT = 16'hABAC;

  function automatic logic [31:0] build_header(
    input logic [15:0] tag,
    input logic [7:0]  seq,
    input logic [7:0]  count
  );
    return {tag, seq, count};
  endfunction

endpackage

// File: rtl/profiler_snapshot_streamer_if.sv
// Valid/ready word stream carrying snapshot frames toward the host readout.
// Signals:
//   out_data  [31:0] - stream word
//   out_valid        - out_data is valid
//   out_ready        - sink accepts the word
//   out_last         - final word of the frame
// Modports: master (the streamer), slave (the sink).
interface profiler_snapshot_streamer_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/profiler_snapshot_streamer_rise_detect.sv
// Rising-edge detector for a synchronous request level.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   req  - request level
//   rise - high for the cycle where req is 1 and was 0 on the previous edge
module profiler_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic rise
);

  logic req_q_r;

  // Previous-cycle copy of the request level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q_r <= 1'b0;
    end else begin
      req_q_r <= req;
    end
  end

  assign rise = req & ~req_q_r;

endmodule

// File: rtl/profiler_snapshot_streamer.sv
// Captures all profiler counters on a snapshot request and streams them as a
// framed word sequence: header {tag, seq, count}, then counter words 0..N-1.
// Optional macro PROFILER_SNAPSHOT_CHECKSUM_EN appends one XOR checksum word
// (header ^ all counters) that carries out_last instead of the final counter.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   snapshot_req      - a rising edge requests a capture
//   counters_in       - packed counters, word i at [32*i+31:32*i]
//   strm              - master side of the output word stream
//   busy              - a frame is in flight
//   frame_seq         - sequence number of the latest captured frame
//   dropped_req_count - requests ignored while busy (saturating)
module profiler_snapshot_streamer
  import profiler_pkg::*;
#(
  parameter int          NUM_COUNTERS = 8,
  parameter logic [15:0] HEADER_TAG   = HEADER_TAG_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      snapshot_req,
  input  logic [NUM_COUNTERS*32-1:0] counters_in,
  profiler_snapshot_streamer_if.master strm,
  output logic                      busy,
  output logic [7:0]                frame_seq,
  output logic [15:0]               dropped_req_count
);

  localparam int               IDX_W      = $clog2(NUM_COUNTERS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_COUNTERS - 1);
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(NUM_COUNTERS - 2);
  localparam logic [7:0]       COUNT_BYTE = 8'(NUM_COUNTERS);

  stream_state_t    state_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_next_s;
  logic [31:0]      shadow_r [NUM_COUNTERS];
  logic [31:0]      out_data_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic             busy_r;
  logic [7:0]       frame_seq_r;
  logic [15:0]      dropped_r;
  logic             rise_s;
  logic             xfer_s;
  logic [31:0]      hdr_next_s;

  profiler_rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .req  (snapshot_req),
    .rise (rise_s)
  );

  assign xfer_s     = out_valid_r & strm.out_ready;
  assign idx_next_s = idx_r + IDX_W'(1);
  assign hdr_next_s = build_header(HEADER_TAG, frame_seq_r + 8'd1, COUNT_BYTE);

`ifdef PROFILER_SNAPSHOT_CHECKSUM_EN
  logic [31:0] csum_r;
  logic [31:0] capture_xor_s;

  // XOR of the header being issued and the counters being captured this cycle
  always_comb begin
    capture_xor_s = hdr_next_s;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      capture_xor_s = capture_xor_s ^ counters_in[32*i +: 32];
    end
  end
`endif

  // Streaming FSM with capture, sequence numbering and drop counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      out_data_r  <= 32'h0000_0000;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      frame_seq_r <= 8'hFF;
      dropped_r   <= 16'h0000;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        shadow_r[i] <= 32'h0000_0000;
      end
`ifdef PROFILER_SNAPSHOT_CHECKSUM_EN
      csum_r      <= 32'h0000_0000;
`endif
    end else begin
      // Any request edge outside IDLE is lost, including one coinciding
      // with the final transfer of a frame.
      if (rise_s && (state_r != IDLE) && (dropped_r != 16'hFFFF)) begin
        dropped_r <= dropped_r + 16'd1;
      end

      case (state_r)
        IDLE: begin
          if (rise_s) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
              shadow_r[i] <= counters_in[32*i +: 32];
            end
`ifdef PROFILER_SNAPSHOT_CHECKSUM_EN
            csum_r      <= capture_xor_s;
`endif
            frame_seq_r <= frame_seq_r + 8'd1;
            out_data_r  <= hdr_next_s;
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= SEND_HDR;
          end
        end

        SEND_HDR: begin
          if (xfer_s) begin
            idx_r      <= '0;
            out_data_r <= shadow_r[0];
            out_last_r <= 1'b0;
            state_r    <= SEND_CNT;
          end
        end

        SEND_CNT: begin
          if (xfer_s) begin
            if (idx_r == LAST_IDX) begin
`ifdef PROFILER_SNAPSHOT_CHECKSUM_EN
              out_data_r  <= csum_r;
              out_last_r  <= 1'b1;
              state_r     <= SEND_CSUM;
`else
              out_data_r  <= 32'h0000_0000;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              busy_r      <= 1'b0;
              state_r     <= IDLE;
`endif
            end else begin
              idx_r      <= idx_next_s;
              out_data_r <= shadow_r[idx_next_s];
`ifdef PROFILER_SNAPSHOT_CHECKSUM_EN
              out_last_r <= 1'b0;
`else
              out_last_r <= (idx_r == PENULT_IDX);
`endif
            end
          end
        end

        SEND_CSUM: begin
          if (xfer_s) begin
            out_data_r  <= 32'h0000_0000;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end

        default: begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign strm.out_data     = out_data_r;
  assign strm.out_valid    = out_valid_r;
  assign strm.out_last     = out_last_r;
  assign busy              = busy_r;
  assign frame_seq         = frame_seq_r;
  assign dropped_req_count = dropped_r;

endmodule

// File: tb/tb_profiler_snapshot_streamer.sv
// Scoreboard bench for profiler_snapshot_streamer (NUM_COUNTERS = 8).
// Stimulus pushes each expected frame into exp_q; the monitor pops and compares
// on every accepted word and checks hold-stability under backpressure.
module tb_profiler_snapshot_streamer;
  import profiler_pkg::*;

`ifdef PROFILER_SNAPSHOT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int NW = CSUM_EN ? 10 : 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          snapshot_req;
  logic [255:0]  counters_in;
  logic          busy;
  logic [7:0]    frame_seq;
  logic [15:0]   dropped_req_count;
  logic          toggle_mode;

  profiler_snapshot_streamer_if intf ();

  profiler_snapshot_streamer #(.NUM_COUNTERS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .snapshot_req      (snapshot_req),
    .counters_in       (counters_in),
    .strm              (intf),
    .busy              (busy),
    .frame_seq         (frame_seq),
    .dropped_req_count (dropped_req_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  logic [32:0] exp_q [$];
  logic [32:0] held;
  logic [32:0] e;
  logic        hold_pending = 1'b0;
  logic [7:0]  exp_seq = 8'hFF;
  logic [31:0] cnt_vals [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Sink ready: constantly high, or alternating every cycle
  always @(posedge clk) begin
    #1 intf.out_ready = toggle_mode ? ~intf.out_ready : 1'b1;
  end

  // Monitor: pop and compare on every accepted word; check stability while stalled
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 64'(intf.out_valid), 64'h1);
        check("hold_word", 64'({intf.out_last, intf.out_data}), 64'(held));
      end
      if (intf.out_valid && intf.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", {intf.out_last, intf.out_data});
        end else begin
          e = exp_q.pop_front();
          check("stream_word", 64'({intf.out_last, intf.out_data}), 64'(e));
          if (xfer_cnt == 0) first_cyc = cyc;
          if (e[32]) last_cyc = cyc;
          xfer_cnt++;
        end
      end
      hold_pending = intf.out_valid && !intf.out_ready;
      held = {intf.out_last, intf.out_data};
    end
  end

  task automatic snapshot();
    logic [31:0] hdr;
    logic [31:0] cs;
    for (int i = 0; i < 8; i++) counters_in[32*i +: 32] = cnt_vals[i];
    exp_seq = exp_seq + 8'd1;
    hdr = {16'hABAC, exp_seq, 8'd8};
    cs = hdr;
    exp_q.push_back({1'b0, hdr});
    for (int i = 0; i < 8; i++) begin
      cs = cs ^ cnt_vals[i];
      exp_q.push_back({(i == 7) && !CSUM_EN, cnt_vals[i]});
    end
    if (CSUM_EN) exp_q.push_back({1'b1, cs});
    xfer_cnt = 0;
    @(posedge clk); #1 snapshot_req = 1'b1;
    @(posedge clk); #1 snapshot_req = 1'b0;
    @(negedge clk);
    check("latency_valid", 64'(intf.out_valid), 64'h1);
    check("busy_in_frame", 64'(busy), 64'h1);
    check("frame_seq", 64'(frame_seq), 64'(exp_seq));
  endtask

  task automatic wait_frame();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    check("frame_done", 64'({busy, exp_q.size() == 0}), 64'h1);
  endtask

  initial begin
    rst = 1'b1;
    snapshot_req = 1'b0;
    counters_in = '0;
    toggle_mode = 1'b0;
    intf.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(intf.out_valid), 64'h0);
    check("rst_last", 64'(intf.out_last), 64'h0);
    check("rst_data", 64'(intf.out_data), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_seq", 64'(frame_seq), 64'hFF);
    check("rst_dropped", 64'(dropped_req_count), 64'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Single snapshot at full throughput
    for (int i = 0; i < 8; i++) cnt_vals[i] = 32'(i + 1);
    snapshot();
    wait_frame();
    check("span_full_rate", 64'(last_cyc - first_cyc), 64'(NW - 1));

    // Backpressure, mid-frame counter change, three dropped requests
    toggle_mode = 1'b1;
    cnt_vals = '{32'h1000_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004,
                 32'h5555_0005, 32'h6666_0006, 32'h7777_0007, 32'h8888_0008};
    snapshot();
    counters_in = {8{32'hDEADBEEF}};
    repeat (3) begin
      @(posedge clk); #1 snapshot_req = 1'b1;
      @(posedge clk); #1 snapshot_req = 1'b0;
    end
    wait_frame();
    check("span_backpressure", 64'(last_cyc - first_cyc), 64'(2 * (NW - 1)));
    check("dropped_three", 64'(dropped_req_count), 64'h3);
    toggle_mode = 1'b0;

    // Level raised during a frame and held past its end: one drop, no retrigger
    cnt_vals = '{32'hA5A5_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000,
                 32'h0F0F_0F0F, 32'h1234_5678, 32'h0000_0000, 32'hCAFE_F00D};
    snapshot();
    @(posedge clk); #1 snapshot_req = 1'b1;
    wait_frame();
    repeat (4) @(negedge clk);
    check("held_level_idle", 64'(busy), 64'h0);
    check("held_level_dropped", 64'(dropped_req_count), 64'h4);
    @(posedge clk); #1 snapshot_req = 1'b0;

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 8; i++) cnt_vals[i] = 32'(32'h100 * (i + 1));
    snapshot();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (xfer_cnt >= 4) break;
    end
    check("reached_word4", 64'(xfer_cnt >= 4), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 64'(intf.out_valid), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_seq", 64'(frame_seq), 64'hFF);
    check("midrst_dropped", 64'(dropped_req_count), 64'h0);
    exp_q.delete();
    exp_seq = 8'hFF;
    @(posedge clk); #1 rst = 1'b0;

    // First frame after reset carries sequence 0
    for (int i = 0; i < 8; i++) cnt_vals[i] = 32'(i + 1);
    snapshot();
    wait_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/profiler_snapshot_streamer.md
Name: profiler_snapshot_streamer

Overview:
Downstream consumer of the cache profiler's eight 32-bit counter outputs. On a snapshot request it atomically captures all counters into shadow registers in a single cycle. It then streams them out as a framed sequence of 32-bit words over a valid/ready interface, toward the host readout path (UART or DMA bridge). Requests that arrive while a frame is in flight are dropped and counted.

Parameters:
NUM_COUNTERS, 8, number of 32-bit counter words per frame (2..255)
HEADER_TAG, 16'hABAC, constant placed in header bits [31:16]

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
snapshot_req  input  1  snapshot request; a rising edge triggers a capture
counters_in  input  NUM_COUNTERS*32  packed counter values; word i is bits [32*i+31:32*i]
out_data  output  32  stream data word
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts the word
out_last  output  1  marks the final word of the frame
busy  output  1  high whenever state is not IDLE
frame_seq  output  8  sequence number of the most recently captured frame
dropped_req_count  output  16  rising edges ignored while busy; saturating

Behaviour:
- Reset values: state IDLE; out_valid, out_last, busy = 0; out_data = 0; frame_seq = 8'hFF (first frame carries 0); dropped_req_count = 0; shadow registers = 0; req_q = 0.
- Edge detect: req_q <= snapshot_req every cycle. rise = snapshot_req & ~req_q.
- States: IDLE, SEND_HDR, SEND_CNT, and SEND_CSUM (SEND_CSUM only when the macro is defined).
- IDLE, on rise:
  - shadow[i] <= counters_in word i, all captured on the same edge.
  - frame_seq <= frame_seq + 1, wrapping 8'hFF -> 8'h00.
  - state <= SEND_HDR.
  - out_valid = 1 from the next cycle, with out_data = {HEADER_TAG, frame_seq_new, NUM_COUNTERS[7:0]}.
  - Latency: first word is valid exactly one cycle after rise is sampled.
- Handshake (AXI-Stream rules):
  - A transfer occurs when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never drops without a transfer.
  - out_ready high continuously gives one word per cycle.
- SEND_HDR:
  - On transfer -> SEND_CNT with idx=0 and out_data = shadow[0].
- SEND_CNT:
  - On transfer with idx < NUM_COUNTERS-1: idx++ and out_data = shadow[idx+1].
  - On transfer at the last idx: go to SEND_CSUM if enabled, else IDLE with out_valid <= 0.
  - out_last = 1 on the final counter word when the macro is absent.
- Request while busy: a rise in any non-IDLE state is not captured. dropped_req_count increments and saturates at 16'hFFFF. A level held high across the end of a frame does not retrigger; a new rising edge is required.
- Frame back-to-back: a rise on the same cycle the final word transfers counts as dropped, because state is not yet IDLE.
- Shadow registers are immutable for the whole frame. counters_in changes during streaming have no effect.
- idx width is $clog2(NUM_COUNTERS). All arithmetic is unsigned.
- rst asserted mid-frame: immediate asynchronous return to the reset values. out_valid drops without a transfer; this is the only permitted exception to the handshake rules.

Optional Feature:
Macro: PROFILER_SNAPSHOT_CHECKSUM_EN.
- Defined:
  - After the last counter word, one extra word is sent: the XOR of the header and all NUM_COUNTERS shadow words.
  - out_last is asserted on that word only.
  - Frame length is NUM_COUNTERS+2 words.
  - The checksum is computed at capture time and held in a register.
- Undefined:
  - No SEND_CSUM state and no checksum register.
  - Frame length is NUM_COUNTERS+1 words.
  - out_last is asserted on the final counter word.

Decomposition:
- Package profiler_pkg holds:
  - the stream_state_t enum (IDLE, SEND_HDR, SEND_CNT, SEND_CSUM);
  - the HEADER_TAG default localparam;
  - a function for header assembly.
- One sub-module, profiler_rise_detect (req_q register plus rise output, async reset), reusable by the other profiling units.

Test Plan:
- Single snapshot: counters_in words = 32'h1..32'h8, out_ready=1, pulse snapshot_req -> 9 words over consecutive cycles: 32'hABAC0008, then 1..8; out_last on word 8; busy low after.
- Backpressure: out_ready toggles 1/0 every cycle -> each word holds stable while ready is low; no word lost or duplicated; frame takes 17 cycles.
- Capture atomicity: change counters_in to 32'hDEADBEEF in every word mid-frame -> streamed words still match the values present at the capture edge.
- Busy drops: three rising edges during a frame -> dropped_req_count=3; second valid frame header carries seq 8'h01.
- Reset mid-frame: assert rst at word 4 -> out_valid=0, busy=0, frame_seq=8'hFF immediately; the next snapshot header has seq 8'h00.
- Checksum (macro defined): counters 1..8 -> 10th word = 32'hABAC0008 ^ 32'h8 = 32'hABAC0000 (XOR of 1..8 is 8), with out_last on it.
